// File: rtl/vx_dcache_rsp_arb_buf_if.sv
// Response bundle between D-cache producers and the merged LSU response port.
// The master side drives the per-input streams and consumes the merged output;
// the slave side is the arbiter/buffer.
interface vx_dcache_rsp_arb_buf_if #(
    parameter int NUM_INPUTS = 2,
    parameter int NUM_REQS   = 4,
    parameter int WORD_SIZE  = 4,
    parameter int TAG_WIDTH  = 8
) ();
    localparam int WORD_W = 8 * WORD_SIZE;
    localparam int SEL_W  = $clog2(NUM_INPUTS);

    logic [NUM_INPUTS-1:0]                 in_valid;
    logic [NUM_INPUTS*NUM_REQS-1:0]        in_tmask;
    logic [NUM_INPUTS*NUM_REQS*WORD_W-1:0] in_data;
    logic [NUM_INPUTS*TAG_WIDTH-1:0]       in_tag;
    logic [NUM_INPUTS-1:0]                 in_ready;

    logic                                  out_valid;
    logic [NUM_REQS-1:0]                   out_tmask;
    logic [NUM_REQS*WORD_W-1:0]            out_data;
    logic [TAG_WIDTH-1:0]                  out_tag;
    logic [SEL_W-1:0]                      out_sel;
    logic                                  out_ready;

    modport master (
        output in_valid, in_tmask, in_data, in_tag,
        input  in_ready,
        input  out_valid, out_tmask, out_data, out_tag, out_sel,
        output out_ready
    );

    modport slave (
        input  in_valid, in_tmask, in_data, in_tag,
        output in_ready,
        output out_valid, out_tmask, out_data, out_tag, out_sel,
        input  out_ready
    );
endinterface

// File: rtl/vx_dcache_rsp_arb_buf.sv
// Buffered N:1 round-robin arbiter for D-cache response streams.
// Each input owns a small FIFO; the arbiter drains the FIFOs into a single
// registered output. Responses with an all-zero lane mask are accepted and dropped.
module vx_dcache_rsp_arb_buf #(
    parameter int NUM_INPUTS = 2,
    parameter int NUM_REQS   = 4,
    parameter int WORD_SIZE  = 4,
    parameter int TAG_WIDTH  = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    vx_dcache_rsp_arb_buf_if.slave  rsp
);
    localparam int WORD_W = 8 * WORD_SIZE;
    localparam int DATA_W = NUM_REQS * WORD_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int SEL_W  = $clog2(NUM_INPUTS);

    logic [AW:0]           wr_ptr    [NUM_INPUTS];
    logic [AW:0]           rd_ptr    [NUM_INPUTS];
    logic [NUM_REQS-1:0]   tmask_mem [NUM_INPUTS][DEPTH];
    logic [DATA_W-1:0]     data_mem  [NUM_INPUTS][DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem   [NUM_INPUTS][DEPTH];

    logic [NUM_INPUTS-1:0] full;
    logic [NUM_INPUTS-1:0] empty;
    logic [NUM_INPUTS-1:0] push;
    logic [NUM_INPUTS-1:0] pop;

    logic [SEL_W-1:0]      rr_ptr;
    logic [SEL_W-1:0]      cand;
    logic [SEL_W-1:0]      grant_idx;
    logic [SEL_W-1:0]      next_rr;
    logic                  grant_any;
    logic                  load;

    logic                  out_valid_q;
    logic [NUM_REQS-1:0]   out_tmask_q;
    logic [DATA_W-1:0]     out_data_q;
    logic [TAG_WIDTH-1:0]  out_tag_q;
    logic [SEL_W-1:0]      out_sel_q;

    // Modular increment of an input index (NUM_INPUTS need not be a power of 2).
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
        return SEL_W'(sum);
    endfunction

    // FIFO status and push qualification; empty-mask responses complete the handshake but are not stored.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            full[i]  = (wr_ptr[i] - rd_ptr[i]) == (AW+1)'(DEPTH);
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            push[i]  = rsp.in_valid[i] && !full[i] && reset
                       && (|rsp.in_tmask[i*NUM_REQS +: NUM_REQS]);
        end
    end

    // Readiness depends only on FIFO occupancy (and reset), never on out_ready.
    assign rsp.in_ready = ~full & {NUM_INPUTS{reset}};

    // Round-robin scan starting at rr_ptr; first non-empty FIFO wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!grant_any && !empty[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        next_rr = wrap_add(grant_idx, 1);
        load    = grant_any && (!out_valid_q || rsp.out_ready);
        for (int i = 0; i < NUM_INPUTS; i++) begin
            pop[i] = load && (grant_idx == SEL_W'(i));
        end
    end

    // FIFO pointers; a reset empties every FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (push[i]) begin
                tmask_mem[i][wr_ptr[i][AW-1:0]] <= rsp.in_tmask[i*NUM_REQS +: NUM_REQS];
                data_mem[i][wr_ptr[i][AW-1:0]]  <= rsp.in_data[i*DATA_W +: DATA_W];
                tag_mem[i][wr_ptr[i][AW-1:0]]   <= rsp.in_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    // Output register and RR pointer; holds while stalled, drops valid when drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_tmask_q <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_sel_q   <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_tmask_q <= tmask_mem[grant_idx][rd_ptr[grant_idx][AW-1:0]];
            out_data_q  <= data_mem[grant_idx][rd_ptr[grant_idx][AW-1:0]];
            out_tag_q   <= tag_mem[grant_idx][rd_ptr[grant_idx][AW-1:0]];
            out_sel_q   <= grant_idx;
            rr_ptr      <= next_rr;
        end else if (rsp.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign rsp.out_valid = out_valid_q;
    assign rsp.out_tmask = out_tmask_q;
    assign rsp.out_data  = out_data_q;
    assign rsp.out_tag   = out_tag_q;
    assign rsp.out_sel   = out_sel_q;
endmodule
